// File: rtl/alu_branch_table_if.sv
// alu_branch_table_if: ALU operand/result and branch-table lookup/update signal bundle.
interface alu_branch_table_if;
  logic [5:0]  funct;
  logic [1:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluctl;
  logic [31:0] out;
  logic        zero;
  logic [31:0] pc4;
  logic        H;
  logic        P;
  logic [31:0] Bdest;
  logic [31:0] PC4d;
  logic        wrt;
  logic        wrp;
  logic [31:0] BdestIN;
  logic        Pin;
  modport master (
    output funct, aluop, a, b, pc4, PC4d, wrt, wrp, BdestIN, Pin,
    input  aluctl, out, zero, H, P, Bdest
  );
  modport slave (
    input  funct, aluop, a, b, pc4, PC4d, wrt, wrp, BdestIN, Pin,
    output aluctl, out, zero, H, P, Bdest
  );
endinterface

// File: rtl/alu_branch_table.sv
// alu_branch_table: ALU control decode + ALU, and a direct-mapped branch target table with 2-bit counters.
// Define BTB_BYPASS_EN to forward same-cycle table writes to the lookup outputs.
module alu_branch_table #(
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input logic clk,
  input logic rst_n,
  alu_branch_table_if.slave bus
);
  localparam int TW = 30 - IDXW;
  logic [3:0]  fctl;
  logic [31:0] res;
  always_comb begin
    fctl = bus.funct == 6'b100000 ? 4'b0010 :
           bus.funct == 6'b100010 ? 4'b0110 :
           bus.funct == 6'b100100 ? 4'b0000 :
           bus.funct == 6'b100101 ? 4'b0001 :
           bus.funct == 6'b101010 ? 4'b0111 :
           bus.funct == 6'b100111 ? 4'b1100 : 4'b1111;
    bus.aluctl = bus.aluop == 2'b00 ? 4'b0010 :
                 bus.aluop == 2'b01 ? 4'b0110 :
                 bus.aluop == 2'b11 ? 4'b0001 : fctl;
    res = bus.aluctl == 4'b0000 ? bus.a & bus.b :
          bus.aluctl == 4'b0001 ? bus.a | bus.b :
          bus.aluctl == 4'b0010 ? bus.a + bus.b :
          bus.aluctl == 4'b0110 ? bus.a - bus.b :
          bus.aluctl == 4'b0111 ? {31'd0, $signed(bus.a) < $signed(bus.b)} :
          bus.aluctl == 4'b1100 ? ~(bus.a | bus.b) : 32'd0;
    bus.out  = res;
    bus.zero = res == 32'd0;
  end
  logic          valid_q [ENTRIES];
  logic [TW-1:0] tag_q   [ENTRIES];
  logic [31:0]   tgt_q   [ENTRIES];
  logic [1:0]    cnt_q   [ENTRIES];
  logic [IDXW-1:0] ui, li;
  logic [TW-1:0]   ut, lt, ntag, ltag;
  logic [31:0]     ntgt, ltgt;
  logic [1:0]      ccur, ncnt, lcnt;
  logic            uhit, we, byp, lv, hit;
  logic            unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.pc4[1:0], bus.PC4d[1:0]};
  always_comb begin
    ui   = bus.PC4d[IDXW+1:2];
    ut   = bus.PC4d[31:2+IDXW];
    li   = bus.pc4[IDXW+1:2];
    lt   = bus.pc4[31:2+IDXW];
    uhit = valid_q[ui] && tag_q[ui] == ut;
    we   = bus.wrt || (bus.wrp && uhit);
    ccur = cnt_q[ui];
    ncnt = bus.wrt ? (bus.Pin ? 2'b10 : 2'b01) :
           bus.Pin ? (ccur == 2'b11 ? ccur : ccur + 2'd1) :
                     (ccur == 2'b00 ? ccur : ccur - 2'd1);
    ntag = bus.wrt ? ut : tag_q[ui];
    ntgt = bus.wrt ? bus.BdestIN : tgt_q[ui];
`ifdef BTB_BYPASS_EN
    byp  = we && ui == li;
`else
    byp  = 1'b0;
`endif
    lv   = byp ? 1'b1 : valid_q[li];
    ltag = byp ? ntag : tag_q[li];
    ltgt = byp ? ntgt : tgt_q[li];
    lcnt = byp ? ncnt : cnt_q[li];
    hit  = rst_n && lv && ltag == lt;
    bus.H     = hit;
    bus.P     = hit && lcnt[1];
    bus.Bdest = hit ? ltgt : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (we) begin
      valid_q[ui] <= 1'b1;
      tag_q[ui]   <= ntag;
      tgt_q[ui]   <= ntgt;
      cnt_q[ui]   <= ncnt;
    end
endmodule

// File: tb/tb_alu_branch_table.sv
// tb_alu_branch_table: directed vectors for ALU decode/compute and branch-table lookup/update/reset.
module tb_alu_branch_table;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  alu_branch_table_if bus ();
  alu_branch_table dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic h, input logic p, input logic [31:0] d);
    bus.pc4 = pc;
    #1;
    chk({tag, ".H"}, {31'd0, bus.H}, {31'd0, h});
    chk({tag, ".P"}, {31'd0, bus.P}, {31'd0, p});
    chk({tag, ".Bdest"}, bus.Bdest, d);
  endtask
  typedef struct {
    logic [1:0] op; logic [5:0] fn; logic [31:0] a, b; logic [3:0] ctl; logic [31:0] o;
  } alu_vec_t;
  alu_vec_t av [11];
  initial begin
    av[0]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1,        4'b0111, 32'h1};
    av[1]  = '{2'b01, 6'b000000, 32'h1234,     32'h1234,     4'b0110, 32'h0};
    av[2]  = '{2'b10, 6'b111111, 32'h5,        32'h3,        4'b1111, 32'h0};
    av[3]  = '{2'b00, 6'b100010, 32'hFFFFFFFF, 32'h2,        4'b0010, 32'h1};
    av[4]  = '{2'b11, 6'b100100, 32'hF0,       32'h0F,       4'b0001, 32'hFF};
    av[5]  = '{2'b10, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 32'h0F000F00};
    av[6]  = '{2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0F0F0F00, 4'b1100, 32'h0000000F};
    av[7]  = '{2'b10, 6'b100010, 32'h3,        32'h5,        4'b0110, 32'hFFFFFFFE};
    av[8]  = '{2'b10, 6'b101010, 32'h1,        32'hFFFFFFFF, 4'b0111, 32'h0};
    av[9]  = '{2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1,        4'b0010, 32'h80000000};
    av[10] = '{2'b10, 6'b100101, 32'hA,        32'h5,        4'b0001, 32'hF};
    bus.funct = '0; bus.aluop = '0; bus.a = '0; bus.b = '0;
    bus.pc4 = 32'h44; bus.PC4d = '0; bus.wrt = 0; bus.wrp = 0; bus.BdestIN = '0; bus.Pin = 0;
    #2;
    look("reset", 32'h44, 0, 0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      bus.aluop = av[i].op; bus.funct = av[i].fn; bus.a = av[i].a; bus.b = av[i].b;
      #1;
      chk($sformatf("alu%0d.ctl", i), {28'd0, bus.aluctl}, {28'd0, av[i].ctl});
      chk($sformatf("alu%0d.out", i), bus.out, av[i].o);
      chk($sformatf("alu%0d.zero", i), {31'd0, bus.zero}, {31'd0, av[i].o == 32'd0});
    end
    step();
    rst_n = 1'b1;
    bus.wrt = 1; bus.PC4d = 32'h44; bus.BdestIN = 32'h100; bus.Pin = 1;
`ifdef BTB_BYPASS_EN
    look("same_cycle", 32'h44, 1, 1, 32'h100);
`else
    look("same_cycle", 32'h44, 0, 0, 32'h0);
`endif
    step();
    bus.wrt = 0;
    look("alloc_hit", 32'h44, 1, 1, 32'h100);
    look("other_tag", 32'h84, 0, 0, 32'h0);
    bus.wrt = 1; bus.PC4d = 32'h48; bus.BdestIN = 32'h200; bus.Pin = 0;
    step();
    bus.wrt = 0;
    look("alloc_nt", 32'h48, 1, 0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      bus.wrp = 1; bus.Pin = 0;
      step();
      bus.wrp = 0;
      look($sformatf("dec%0d", i), 32'h48, 1, 0, 32'h200);
    end
    bus.wrp = 1; bus.Pin = 1;
    step();
    bus.wrp = 0;
    look("inc1", 32'h48, 1, 0, 32'h200);
    bus.wrp = 1;
    step();
    bus.wrp = 0;
    look("inc2", 32'h48, 1, 1, 32'h200);
    bus.wrp = 1; bus.Pin = 0; bus.PC4d = 32'h88;
    step();
    bus.wrp = 0;
    look("miss_wrp_keep", 32'h48, 1, 1, 32'h200);
    look("miss_wrp_noalloc", 32'h88, 0, 0, 32'h0);
    bus.wrt = 1; bus.wrp = 1; bus.PC4d = 32'h48; bus.BdestIN = 32'h300; bus.Pin = 1;
    step();
    bus.wrt = 0; bus.wrp = 0;
    look("wrt_prec", 32'h48, 1, 1, 32'h300);
    bus.wrp = 1; bus.Pin = 0;
    step();
    bus.wrp = 0;
    look("wrt_prec_cnt", 32'h48, 1, 0, 32'h300);
    #2;
    rst_n = 1'b0;
    look("async_rst", 32'h48, 0, 0, 32'h0);
    look("async_rst44", 32'h44, 0, 0, 32'h0);
    bus.wrt = 1; bus.PC4d = 32'h44; bus.BdestIN = 32'h500; bus.Pin = 1;
    step();
    bus.wrt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    look("rst_beats_wrt", 32'h44, 0, 0, 32'h0);
    step();
    look("post_rst", 32'h44, 0, 0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
